d_trig_arbiter: RTL and testbench
=================================

Name: d_trig_arbiter

Overview:
- Round-robin write arbiter and sequencer for a shared bank of enabled D flip-flops (d_trig style: clock, clear, enable, d, q).
- Shares one DATA_W-bit register between NUM_REQ requesters. Drives the register's enable, data and clear pins, and returns one-hot grant and acknowledge to the winning requester.
- Sits between requester logic and the d_trig bank. It is the only block allowed to drive the bank's enable/clear/d pins.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, width of the shared register and of each requester's data.
- CNT_W, 16, width of the completed-write counter.

Ports:
- i_clk  input  1  system clock, rising edge.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_req  input  NUM_REQ  per-requester write request, level.
- i_data  input  NUM_REQ*DATA_W  requester data; requester k occupies bits [k*DATA_W +: DATA_W].
- i_clr_req  input  1  request to clear the shared register, level or pulse.
- o_gnt  output  NUM_REQ  one-hot grant, high only in WRITE.
- o_ack  output  1  write acknowledge, high only in WRITE.
- o_enable  output  1  to d_trig bank i_enable.
- o_d  output  DATA_W  to d_trig bank i_d.
- o_clr  output  1  to d_trig bank i_clr, active-high, one-cycle pulse.
- o_busy  output  1  high whenever state is not IDLE.
- o_wr_cnt  output  CNT_W  number of completed writes.

Behaviour:
- Reset (asynchronous assert, synchronous release), applies at any time including mid-WRITE or mid-CLEAR:
  - state = IDLE.
  - o_gnt, o_ack, o_enable, o_clr, o_busy = 0.
  - o_d = 0, o_wr_cnt = 0.
  - RR pointer = 0, clr_pend = 0.
- All outputs are registered. There is no combinational path from inputs to outputs.
- States and transitions:
  - IDLE:
    - If clr_pend or i_clr_req -> CLEAR. Clear has priority over writes.
    - Else if any i_req -> WRITE.
    - Else stay in IDLE.
  - WRITE: lasts exactly 1 cycle -> IDLE.
  - CLEAR: lasts exactly 1 cycle -> IDLE.
- Arbitration (on the IDLE->WRITE edge):
  - Winner w is the first asserted i_req searching upward from the RR pointer, wrapping from NUM_REQ-1 to 0.
  - At that edge: o_gnt <= one-hot(w), o_d <= i_data[w], o_enable <= 1, o_ack <= 1.
  - RR pointer <= (w+1) mod NUM_REQ.
- Timing: request sampled in IDLE cycle N. Enable, ack and grant are high in cycle N+1. The bank captures o_d at the end of N+1.
  - Minimum 2 cycles per write. Peak throughput is one write per 2 cycles.
- Request handling:
  - A requester drops i_req by the end of its ack cycle to end its request.
  - If i_req is still high in the following IDLE cycle, it is a new request and is arbitrated normally. The RR rotation guarantees other requesters are served first.
- o_d holds its last written value outside WRITE. It changes only on the IDLE->WRITE edge and is cleared only by reset.
- CLEAR cycle: o_clr = 1, o_enable = 0, o_gnt = 0, o_ack = 0. clr_pend <= 0.
- i_clr_req seen during WRITE or CLEAR sets clr_pend. It is served in CLEAR right after the next IDLE cycle. Multiple clear requests collapse into one clear.
- i_clr_req and i_req asserted in the same IDLE cycle: CLEAR is taken first. The write is granted on the next IDLE cycle if i_req is still held.
- o_wr_cnt increments by 1 at the end of each WRITE cycle. It wraps modulo 2^CNT_W with no saturation and no flag.
- Unused or out-of-range pointer values cannot occur. The pointer is always below NUM_REQ.

Decomposition:
- Shared package d_trig_pkg holds:
  - state encoding constants: ST_IDLE = 2'd0, ST_WRITE = 2'd1, ST_CLEAR = 2'd2.
  - default widths DATA_W and CNT_W.
- One sub-module: rr_pick. It is combinational and takes req vector + pointer, returning a one-hot winner and a found flag. It is reused by other arbiters in the codebase.
- FSM, data register and counter stay in d_trig_arbiter.

Test Plan:
- Reset, then idle with no req: all outputs 0 and o_busy = 0 for 10 cycles. Assert i_rst_n = 0 mid-WRITE: o_enable, o_gnt and o_ack drop to 0 immediately, without waiting for a clock edge.
- Single write: i_req = 4'b0100, i_data[2] = 8'hA5, request held 1 cycle -> next cycle o_gnt = 4'b0100, o_ack = 1, o_enable = 1, o_d = 8'hA5. Bank q = 8'hA5 after that edge. o_wr_cnt = 1.
- All four requesters held high continuously -> grants 0001, 0010, 0100, 1000, 0001 on every second cycle. o_wr_cnt counts 1..5.
- i_clr_req and i_req[1] asserted in the same IDLE cycle -> o_clr pulse first. o_gnt = 4'b0010 two cycles later. Bank q = 0 and then i_data[1].
- i_clr_req pulsed twice during a WRITE cycle -> exactly one o_clr pulse, two cycles after the WRITE. clr_pend clears.
- Counter wrap with CNT_W = 4: 17 writes -> o_wr_cnt goes 15 then 0 then 1, with no other side effects.

Source files
------------

// File: rtl/d_trig_arbiter_pkg.sv
// Shared definitions for the d_trig write arbiter.
//   D_TRIG_NUM_REQ / D_TRIG_DATA_W / D_TRIG_CNT_W : default sizes
//   state_t : arbiter FSM encoding (IDLE / WRITE / CLEAR)
package d_trig_pkg;

   localparam int unsigned D_TRIG_NUM_REQ = 4;
   localparam int unsigned D_TRIG_DATA_W  = 8;
   localparam int unsigned D_TRIG_CNT_W   = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_CLEAR = 2'd2
   } state_t;

endpackage

// File: rtl/d_trig_arbiter_if.sv
// Requester-side bus of the d_trig arbiter.
//   i_req      : per-requester write request (level)
//   i_data     : requester data, requester k at [k*DATA_W +: DATA_W]
//   i_clr_req  : clear request for the shared register
//   o_gnt/o_ack: one-hot grant and acknowledge, WRITE cycle only
//   o_enable/o_d/o_clr : pins driven into the d_trig bank
//   o_busy     : arbiter not idle
//   o_wr_cnt   : completed-write counter
// slave modport is taken by the arbiter, master by the requester side.
interface d_trig_arbiter_if
   import d_trig_pkg::*;
#(
   parameter int unsigned NUM_REQ = D_TRIG_NUM_REQ,
   parameter int unsigned DATA_W  = D_TRIG_DATA_W,
   parameter int unsigned CNT_W   = D_TRIG_CNT_W
);
   logic [NUM_REQ-1:0]        i_req;
   logic [NUM_REQ*DATA_W-1:0] i_data;
   logic                      i_clr_req;
   logic [NUM_REQ-1:0]        o_gnt;
   logic                      o_ack;
   logic                      o_enable;
   logic [DATA_W-1:0]         o_d;
   logic                      o_clr;
   logic                      o_busy;
   logic [CNT_W-1:0]          o_wr_cnt;

   modport slave (
      input  i_req, i_data, i_clr_req,
      output o_gnt, o_ack, o_enable, o_d, o_clr, o_busy, o_wr_cnt
   );

   modport master (
      output i_req, i_data, i_clr_req,
      input  o_gnt, o_ack, o_enable, o_d, o_clr, o_busy, o_wr_cnt
   );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   req   : request vector
//   ptr   : highest-priority index (must be below N)
//   gnt   : one-hot winner, first request at or above ptr, wrapping
//   found : at least one request present
module rr_pick #(
   parameter int unsigned N     = 4,
   parameter int unsigned PTR_W = 2
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     gnt,
   output logic             found
);

   logic [PTR_W-1:0] idx;

   always_comb begin
      gnt   = '0;
      found = 1'b0;
      idx   = '0;
      for (int unsigned i = 0; i < N; i++) begin
         idx = PTR_W'((32'(ptr) + i) % N);
         if (!found && req[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/d_trig_arbiter.sv
// Round-robin write arbiter / sequencer for a shared d_trig register bank.
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   bus     : requester bus and bank pins (see d_trig_arbiter_if)
// One write takes IDLE->WRITE (2 cycles minimum); clears take IDLE->CLEAR
// and have priority over writes. All bus outputs are registered.
module d_trig_arbiter
   import d_trig_pkg::*;
#(
   parameter int unsigned NUM_REQ = D_TRIG_NUM_REQ,
   parameter int unsigned DATA_W  = D_TRIG_DATA_W,
   parameter int unsigned CNT_W   = D_TRIG_CNT_W
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   d_trig_arbiter_if.slave  bus
);

   localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   state_t               state, state_nxt;
   logic [PTR_W-1:0]     ptr, ptr_nxt;
   logic                 clr_pend, clr_pend_nxt;
   logic [NUM_REQ-1:0]   pick_gnt;
   logic                 pick_found;
   logic [PTR_W-1:0]     win_idx;

   logic [NUM_REQ-1:0]   gnt_q, gnt_nxt;
   logic                 ack_q, ack_nxt;
   logic                 en_q, en_nxt;
   logic                 clr_q, clr_nxt;
   logic                 busy_q, busy_nxt;
   logic [DATA_W-1:0]    d_q, d_nxt;
   logic [CNT_W-1:0]     cnt_q, cnt_nxt;

   rr_pick #(
      .N     (NUM_REQ),
      .PTR_W (PTR_W)
   ) u_rr_pick (
      .req   (bus.i_req),
      .ptr   (ptr),
      .gnt   (pick_gnt),
      .found (pick_found)
   );

   // Binary index of the one-hot winner, used for the data mux and pointer.
   always_comb begin
      win_idx = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (pick_gnt[k]) win_idx = PTR_W'(k);
      end
   end

   // State and registered-output storage.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state    <= ST_IDLE;
         ptr      <= '0;
         clr_pend <= 1'b0;
         gnt_q    <= '0;
         ack_q    <= 1'b0;
         en_q     <= 1'b0;
         clr_q    <= 1'b0;
         busy_q   <= 1'b0;
         d_q      <= '0;
         cnt_q    <= '0;
      end else begin
         state    <= state_nxt;
         ptr      <= ptr_nxt;
         clr_pend <= clr_pend_nxt;
         gnt_q    <= gnt_nxt;
         ack_q    <= ack_nxt;
         en_q     <= en_nxt;
         clr_q    <= clr_nxt;
         busy_q   <= busy_nxt;
         d_q      <= d_nxt;
         cnt_q    <= cnt_nxt;
      end
   end

   // Next state: clear (pending or new) beats any write request.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (clr_pend || bus.i_clr_req) state_nxt = ST_CLEAR;
            else if (pick_found)           state_nxt = ST_WRITE;
         end
         ST_WRITE: state_nxt = ST_IDLE;
         ST_CLEAR: state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Outputs are computed one cycle ahead from state_nxt so that every
   // bus output comes straight from a flop.
   always_comb begin
      gnt_nxt      = '0;
      ack_nxt      = 1'b0;
      en_nxt       = 1'b0;
      clr_nxt      = 1'b0;
      busy_nxt     = (state_nxt != ST_IDLE);
      d_nxt        = d_q;
      ptr_nxt      = ptr;
      clr_pend_nxt = clr_pend;
      cnt_nxt      = cnt_q;
      if (state == ST_WRITE) cnt_nxt = cnt_q + CNT_W'(1);
      case (state)
         ST_IDLE: begin
            if (state_nxt == ST_WRITE) begin
               gnt_nxt = pick_gnt;
               ack_nxt = 1'b1;
               en_nxt  = 1'b1;
               d_nxt   = bus.i_data[win_idx*DATA_W +: DATA_W];
               ptr_nxt = (win_idx == PTR_W'(NUM_REQ-1)) ? '0 : win_idx + PTR_W'(1);
            end else if (state_nxt == ST_CLEAR) begin
               clr_nxt = 1'b1;
            end
         end
         // A clear seen while busy is remembered; repeats collapse into one.
         ST_WRITE: clr_pend_nxt = clr_pend | bus.i_clr_req;
         ST_CLEAR: clr_pend_nxt = bus.i_clr_req;
         default:  clr_pend_nxt = clr_pend;
      endcase
   end

   assign bus.o_gnt    = gnt_q;
   assign bus.o_ack    = ack_q;
   assign bus.o_enable = en_q;
   assign bus.o_clr    = clr_q;
   assign bus.o_busy   = busy_q;
   assign bus.o_d      = d_q;
   assign bus.o_wr_cnt = cnt_q;

endmodule

// File: tb/tb_d_trig_arbiter.sv
// Self-checking bench for d_trig_arbiter: directed table, hand sequences for
// clear/reset/wrap corners, then random traffic against a behavioural model.
// A second instance with a 4-bit counter shares all inputs.
module tb_d_trig_arbiter;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   d_trig_arbiter_if #(.NUM_REQ(4), .DATA_W(8), .CNT_W(16)) bus ();
   d_trig_arbiter_if #(.NUM_REQ(4), .DATA_W(8), .CNT_W(4))  bus4 ();

   assign bus4.i_req     = bus.i_req;
   assign bus4.i_data    = bus.i_data;
   assign bus4.i_clr_req = bus.i_clr_req;

   d_trig_arbiter #(.NUM_REQ(4), .DATA_W(8), .CNT_W(16)) u_dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   d_trig_arbiter #(.NUM_REQ(4), .DATA_W(8), .CNT_W(4)) u_dut4 (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus4)
   );

   // Shared d_trig bank driven by the main instance.
   logic [7:0] bank_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)            bank_q <= '0;
      else if (bus.o_clr)    bank_q <= '0;
      else if (bus.o_enable) bank_q <= bus.o_d;
   end

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: mode 0 idle, 1 writing, 2 clearing.
   int          m_mode, m_ptr, m_win;
   bit          m_pend;
   int unsigned m_cnt;
   logic [3:0]  e_gnt;
   logic        e_en, e_clr;
   logic [7:0]  e_d, m_q;

   task automatic model_reset();
      m_mode = 0; m_ptr = 0; m_win = 0; m_pend = 1'b0; m_cnt = 0;
      e_gnt = '0; e_en = 1'b0; e_clr = 1'b0; e_d = '0; m_q = '0;
   endtask

   task automatic model_step(input logic [3:0] req, input logic [31:0] data, input logic clr);
      int nxt;
      nxt = 0;
      if (e_clr)     m_q = '0;
      else if (e_en) m_q = e_d;
      if (m_mode == 1) m_cnt++;
      if (m_mode == 0) begin
         if (m_pend || clr) nxt = 2;
         else if (req != 4'b0) begin
            m_win = -1;
            for (int i = 0; i < 4; i++)
               if (m_win < 0 && req[(m_ptr + i) % 4]) m_win = (m_ptr + i) % 4;
            nxt = 1;
            m_ptr = (m_win + 1) % 4;
         end
      end else if (m_mode == 1) begin
         m_pend = m_pend | clr;
      end else begin
         m_pend = clr;
      end
      m_mode = nxt;
      e_en  = (nxt == 1);
      e_clr = (nxt == 2);
      e_gnt = (nxt == 1) ? 4'(1 << m_win) : 4'b0;
      if (nxt == 1) e_d = data[m_win*8 +: 8];
   endtask

   task automatic check_all();
      chk("gnt",     bus.o_gnt,     e_gnt);
      chk("ack",     bus.o_ack,     e_en);
      chk("enable",  bus.o_enable,  e_en);
      chk("clr",     bus.o_clr,     e_clr);
      chk("busy",    bus.o_busy,    m_mode != 0);
      chk("d",       bus.o_d,       e_d);
      chk("wr_cnt",  bus.o_wr_cnt,  m_cnt % 65536);
      chk("bank_q",  bank_q,        m_q);
      chk("gnt4",    bus4.o_gnt,    e_gnt);
      chk("ack4",    bus4.o_ack,    e_en);
      chk("enable4", bus4.o_enable, e_en);
      chk("clr4",    bus4.o_clr,    e_clr);
      chk("busy4",   bus4.o_busy,   m_mode != 0);
      chk("d4",      bus4.o_d,      e_d);
      chk("wr_cnt4", bus4.o_wr_cnt, m_cnt % 16);
   endtask

   // Inputs are applied at posedge+1; outputs are checked at the next posedge+1.
   task automatic cycle(input logic [3:0] req, input logic [31:0] data, input logic clr);
      bus.i_req = req; bus.i_data = data; bus.i_clr_req = clr;
      model_step(req, data, clr);
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus.i_req = '0; bus.i_data = '0; bus.i_clr_req = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      check_all();
   endtask

   typedef struct {
      logic [3:0]  req;
      logic        clr;
      logic [3:0]  gnt;
      logic        ack;
      logic        clr_o;
      logic [7:0]  d;
      int unsigned cnt;
      logic [7:0]  q;
      logic        busy;
   } vec_t;

   vec_t tbl [6];
   localparam logic [31:0] TBL_DATA = 32'h00A5_3C00;  // req1 = 3C, req2 = A5

   initial begin
      #1_000_000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   initial begin
      // Starts after the round-robin block: pointer 1, count 5, bank holds 10.
      tbl[0] = '{4'b0100, 1'b0, 4'b0100, 1'b1, 1'b0, 8'hA5, 5, 8'h10, 1'b1};
      tbl[1] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 8'hA5, 6, 8'hA5, 1'b0};
      tbl[2] = '{4'b0010, 1'b1, 4'b0000, 1'b0, 1'b1, 8'hA5, 6, 8'hA5, 1'b1};
      tbl[3] = '{4'b0010, 1'b0, 4'b0000, 1'b0, 1'b0, 8'hA5, 6, 8'h00, 1'b0};
      tbl[4] = '{4'b0010, 1'b0, 4'b0010, 1'b1, 1'b0, 8'h3C, 6, 8'h00, 1'b1};
      tbl[5] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 8'h3C, 7, 8'h3C, 1'b0};

      do_reset();

      for (int i = 0; i < 10; i++) begin
         cycle(4'b0000, 32'h0, 1'b0);
         chk("idle_busy", bus.o_busy, 0);
      end

      // All requesters held: grants rotate every second cycle.
      for (int i = 1; i <= 10; i++) begin
         cycle(4'b1111, 32'h1312_1110, 1'b0);
         if (i % 2 == 1) begin
            chk("rr_gnt", bus.o_gnt, 1 << (((i - 1) / 2) % 4));
            chk("rr_cnt", bus.o_wr_cnt, (i - 1) / 2);
         end
      end
      cycle(4'b0000, 32'h0, 1'b0);
      chk("rr_cnt_end", bus.o_wr_cnt, 5);

      for (int r = 0; r < 6; r++) begin
         cycle(tbl[r].req, TBL_DATA, tbl[r].clr);
         chk("tbl_gnt",  bus.o_gnt,    tbl[r].gnt);
         chk("tbl_ack",  bus.o_ack,    tbl[r].ack);
         chk("tbl_en",   bus.o_enable, tbl[r].ack);
         chk("tbl_clr",  bus.o_clr,    tbl[r].clr_o);
         chk("tbl_d",    bus.o_d,      tbl[r].d);
         chk("tbl_cnt",  bus.o_wr_cnt, tbl[r].cnt);
         chk("tbl_q",    bank_q,       tbl[r].q);
         chk("tbl_busy", bus.o_busy,   tbl[r].busy);
      end

      // Two clear pulses inside one WRITE cycle give a single clear later.
      cycle(4'b0001, TBL_DATA, 1'b0);
      chk("dbl_write", bus.o_enable, 1);
      bus.i_req = '0;
      bus.i_clr_req = 1'b1; #2;
      bus.i_clr_req = 1'b0; #2;
      bus.i_clr_req = 1'b1;
      model_step(4'b0000, TBL_DATA, 1'b1);
      @(posedge clk); #1;
      check_all();
      chk("dbl_clr_a", bus.o_clr, 0);
      cycle(4'b0000, TBL_DATA, 1'b0);
      chk("dbl_clr_b", bus.o_clr, 1);
      cycle(4'b0000, TBL_DATA, 1'b0);
      chk("dbl_clr_c", bus.o_clr, 0);
      cycle(4'b0000, TBL_DATA, 1'b0);
      chk("dbl_clr_d", bus.o_clr, 0);
      chk("dbl_busy",  bus.o_busy, 0);

      // Asynchronous reset in the middle of a WRITE cycle.
      cycle(4'b1000, 32'h7700_0000, 1'b0);
      chk("mid_gnt_pre", bus.o_gnt, 4'b1000);
      rst_n = 1'b0;
      #1;
      chk("rst_enable", bus.o_enable, 0);
      chk("rst_gnt",    bus.o_gnt,    0);
      chk("rst_ack",    bus.o_ack,    0);
      chk("rst_busy",   bus.o_busy,   0);
      chk("rst_cnt",    bus.o_wr_cnt, 0);
      chk("rst_d",      bus.o_d,      0);
      bus.i_req = '0; bus.i_clr_req = 1'b0;
      model_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;
      check_all();

      // 17 writes: the 4-bit counter passes 15 -> 0 -> 1.
      for (int i = 1; i <= 34; i++) begin
         cycle(4'b0001, 32'h0000_00C3, 1'b0);
         if (i % 2 == 0) begin
            chk("wrap_cnt4", bus4.o_wr_cnt, (i / 2) % 16);
            chk("wrap_cnt",  bus.o_wr_cnt,  i / 2);
         end
      end

      for (int i = 0; i < 400; i++) begin
         cycle(4'($urandom_range(0, 15)), $urandom, ($urandom_range(0, 5) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
